// File: rtl/swap_pkg.sv
// swap_pkg: shared types for the initiator swap response remapper.
//   swap_state_e : drain-control FSM states
//   swap_cfg_t   : one swap mapping (enable, source lane, target lane)
// SWAP_IDX_W is the lane index width the mapping struct is built with; it
// must match the LOG_N_INIT of the instantiating block.
package swap_pkg;

  localparam int unsigned SWAP_IDX_W = 3;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } swap_state_e;

  typedef struct packed {
    logic                  select;
    logic [SWAP_IDX_W-1:0] source;
    logic [SWAP_IDX_W-1:0] target;
  } swap_cfg_t;

endpackage

// File: rtl/swap_out_cnt.sv
// swap_out_cnt: saturating up/down counter of outstanding redirected
// transactions.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc_i      : count one new transaction
//   dec_i      : retire one transaction
//   full_o     : counter at MAX_OUT
//   zero_o     : counter at 0
// Simultaneous inc/dec holds the value; the count never wraps.
module swap_out_cnt #(
  parameter int unsigned MAX_OUT = 15,
  parameter int unsigned CNT_W   = $clog2(MAX_OUT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign full_o = (cnt_q == CNT_W'(MAX_OUT));
  assign zero_o = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && !full_o) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i && !zero_o) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/swap_rsp_remap.sv
// swap_rsp_remap: response-path remapper for the initiator swap.
// Owns the active select/source/target mapping. A new mapping is accepted
// in ST_IDLE, held pending in ST_DRAIN (request side stalled) until every
// redirected transaction under the old mapping has returned, then applied.
// Responses pass through combinationally; those addressed to the target
// lane are steered back to the source lane while the swap is active.
// Ports:
//   cfg_valid_i/cfg_ready_o, cfg_select_i/source_i/target_i : mapping request
//   select_o/source_o/target_o : active mapping to the request side
//   req_hs_i, req_stall_o      : request handshake on target lane, stall
//   rsp_valid_i/ready_o/last_i/dest_i : response from slave side
//   rsp_valid_o/ready_i/dest_o        : response to initiator side
//   err_o                      : sticky protocol error
// Build option: define SWAP_RSP_ERR_CHECK_EN to build the err_o checker;
// otherwise err_o is tied low.
module swap_rsp_remap
  import swap_pkg::*;
#(
  parameter int unsigned N_INIT_PORT = 8,
  parameter int unsigned LOG_N_INIT  = $clog2(N_INIT_PORT),
  parameter int unsigned MAX_OUT     = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_valid_i,
  output logic                  cfg_ready_o,
  input  logic                  cfg_select_i,
  input  logic [LOG_N_INIT-1:0] cfg_source_i,
  input  logic [LOG_N_INIT-1:0] cfg_target_i,
  output logic                  select_o,
  output logic [LOG_N_INIT-1:0] source_o,
  output logic [LOG_N_INIT-1:0] target_o,
  input  logic                  req_hs_i,
  output logic                  req_stall_o,
  input  logic                  rsp_valid_i,
  output logic                  rsp_ready_o,
  input  logic                  rsp_last_i,
  input  logic [LOG_N_INIT-1:0] rsp_dest_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [LOG_N_INIT-1:0] rsp_dest_o,
  output logic                  err_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

  swap_state_e state_q, state_d;
  swap_cfg_t   map_q, map_d;
  swap_cfg_t   pend_q, pend_d;

  logic cnt_inc, cnt_dec, cnt_full, cnt_zero;
  logic rsp_to_target;

  assign select_o = map_q.select;
  assign source_o = map_q.source;
  assign target_o = map_q.target;

  assign rsp_to_target = map_q.select && (rsp_dest_i == map_q.target);

  assign rsp_valid_o = rsp_valid_i;
  assign rsp_ready_o = rsp_ready_i;
  assign rsp_dest_o  = rsp_to_target ? map_q.source : rsp_dest_i;

  assign cnt_inc = req_hs_i && map_q.select;
  assign cnt_dec = rsp_valid_i && rsp_ready_i && rsp_last_i && rsp_to_target;

  swap_out_cnt #(
    .MAX_OUT (MAX_OUT),
    .CNT_W   (CNT_W)
  ) u_out_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_i  (cnt_inc),
    .dec_i  (cnt_dec),
    .full_o (cnt_full),
    .zero_o (cnt_zero)
  );

  assign cfg_ready_o = (state_q == ST_IDLE);
  assign req_stall_o = (state_q == ST_DRAIN) || cnt_full;

  // Even a disabling or unchanged mapping goes through ST_DRAIN so the
  // request side never sees a mapping change with traffic outstanding.
  always_comb begin
    state_d = state_q;
    map_d   = map_q;
    pend_d  = pend_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_valid_i) begin
          pend_d  = '{select: cfg_select_i, source: cfg_source_i, target: cfg_target_i};
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (cnt_zero) begin
          map_d   = pend_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      map_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      map_q   <= map_d;
      pend_q  <= pend_d;
    end
  end

`ifdef SWAP_RSP_ERR_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q
          | (req_hs_i && req_stall_o)
          | (cnt_dec && cnt_zero)
          | (rsp_valid_i && map_q.select && (rsp_dest_i == map_q.source));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_swap_rsp_remap.sv
module tb_swap_rsp_remap;

  localparam int MAXO = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_valid_i = 1'b0, cfg_ready_o, cfg_select_i = 1'b0;
  logic [2:0] cfg_source_i = '0, cfg_target_i = '0;
  logic       select_o;
  logic [2:0] source_o, target_o;
  logic       req_hs_i = 1'b0, req_stall_o;
  logic       rsp_valid_i = 1'b0, rsp_ready_o, rsp_last_i = 1'b0;
  logic [2:0] rsp_dest_i = '0;
  logic       rsp_valid_o, rsp_ready_i = 1'b0;
  logic [2:0] rsp_dest_o;
  logic       err_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  swap_rsp_remap #(
    .N_INIT_PORT (8),
    .LOG_N_INIT  (3),
    .MAX_OUT     (MAXO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_valid_i  (cfg_valid_i),
    .cfg_ready_o  (cfg_ready_o),
    .cfg_select_i (cfg_select_i),
    .cfg_source_i (cfg_source_i),
    .cfg_target_i (cfg_target_i),
    .select_o     (select_o),
    .source_o     (source_o),
    .target_o     (target_o),
    .req_hs_i     (req_hs_i),
    .req_stall_o  (req_stall_o),
    .rsp_valid_i  (rsp_valid_i),
    .rsp_ready_o  (rsp_ready_o),
    .rsp_last_i   (rsp_last_i),
    .rsp_dest_i   (rsp_dest_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_dest_o   (rsp_dest_o),
    .err_o        (err_o)
  );

  // Reference model: mapping, outstanding count, pending request, error flag.
  int m_sel, m_src, m_tgt, m_out, m_err;
  int m_pending;  // 1 while a new mapping waits for the old traffic to return
  int p_sel, p_src, p_tgt;

`ifdef SWAP_RSP_ERR_CHECK_EN
  localparam int ERR_EN = 1;
`else
  localparam int ERR_EN = 0;
`endif

  task automatic model_reset();
    m_sel = 0; m_src = 0; m_tgt = 0; m_out = 0; m_err = 0;
    m_pending = 0; p_sel = 0; p_src = 0; p_tgt = 0;
  endtask

  function automatic int exp_stall();
    return (m_pending != 0 || m_out == MAXO) ? 1 : 0;
  endfunction

  function automatic int exp_dest();
    return (m_sel == 1 && int'(rsp_dest_i) == m_tgt) ? m_src : int'(rsp_dest_i);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    total++;
    assert (obs === 32'(exp))
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("select", 32'(select_o), m_sel);
    chk("source", 32'(source_o), m_src);
    chk("target", 32'(target_o), m_tgt);
    chk("cfg_ready", 32'(cfg_ready_o), (m_pending != 0) ? 0 : 1);
    chk("req_stall", 32'(req_stall_o), exp_stall());
    chk("rsp_valid_o", 32'(rsp_valid_o), int'(rsp_valid_i));
    chk("rsp_ready_o", 32'(rsp_ready_o), int'(rsp_ready_i));
    chk("rsp_dest_o", 32'(rsp_dest_o), exp_dest());
    chk("err", 32'(err_o), m_err);
  endtask

  // Advance the model over one clock edge using the inputs currently applied.
  task automatic model_edge();
    int fin, nxt;
    fin = (rsp_valid_i && rsp_ready_i && rsp_last_i && m_sel == 1
           && int'(rsp_dest_i) == m_tgt) ? 1 : 0;
    if (ERR_EN != 0) begin
      if ((req_hs_i && exp_stall() != 0) || (fin != 0 && m_out == 0)
          || (rsp_valid_i && m_sel == 1 && int'(rsp_dest_i) == m_src))
        m_err = 1;
    end
    nxt = m_out + ((req_hs_i && m_sel == 1) ? 1 : 0) - fin;
    if (nxt < 0) nxt = 0;
    if (nxt > MAXO) nxt = MAXO;
    if (m_pending != 0 && m_out == 0) begin
      m_sel = p_sel; m_src = p_src; m_tgt = p_tgt;
      m_pending = 0;
    end else if (m_pending == 0 && cfg_valid_i) begin
      p_sel = int'(cfg_select_i); p_src = int'(cfg_source_i); p_tgt = int'(cfg_target_i);
      m_pending = 1;
    end
    m_out = nxt;
  endtask

  // Called at a falling edge: apply inputs, check, take the rising edge,
  // and return at the next falling edge.
  task automatic step(input bit cv, input bit cs, input int csrc, input int ctgt,
                      input bit hs, input bit rv, input bit rr, input bit rl,
                      input int rd);
    cfg_valid_i  = cv;
    cfg_select_i = cs;
    cfg_source_i = 3'(csrc);
    cfg_target_i = 3'(ctgt);
    req_hs_i     = hs;
    rsp_valid_i  = rv;
    rsp_ready_i  = rr;
    rsp_last_i   = rl;
    rsp_dest_i   = 3'(rd);
    #1;
    check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();                     step(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic hs1();                      step(0, 0, 0, 0, 1, 0, 0, 0, 0); endtask
  task automatic fin(input int rd);          step(0, 0, 0, 0, 0, 1, 1, 1, rd); endtask
  task automatic cfg(input bit s, input int a, input int b); step(1, s, a, b, 0, 0, 0, 0, 0); endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_select"}, 32'(select_o), 0);
    chk({tag, "_source"}, 32'(source_o), 0);
    chk({tag, "_target"}, 32'(target_o), 0);
    chk({tag, "_cfg_ready"}, 32'(cfg_ready_o), 1);
    chk({tag, "_stall"}, 32'(req_stall_o), 0);
    chk({tag, "_err"}, 32'(err_o), 0);
  endtask

  initial begin
    model_reset();
    // Reset
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Configure 2->5 with no traffic
    cfg(1, 2, 5);
    chk("plan_cfg_ready_t1", 32'(cfg_ready_o), 0);
    chk("plan_select_t1", 32'(select_o), 0);
    idle();
    chk("plan_select_t2", 32'(select_o), 1);
    chk("plan_source_t2", 32'(source_o), 2);
    chk("plan_target_t2", 32'(target_o), 5);
    chk("plan_cfg_ready_t2", 32'(cfg_ready_o), 1);

    // Response remap and pass-through
    step(0, 0, 0, 0, 0, 1, 1, 0, 5);
    chk("plan_dest_5_to_2", 32'(rsp_dest_o), 2);
    step(0, 0, 0, 0, 0, 1, 1, 0, 3);
    chk("plan_dest_3_kept", 32'(rsp_dest_o), 3);
    step(0, 0, 0, 0, 0, 1, 0, 1, 5);
    step(0, 0, 0, 0, 0, 0, 1, 1, 5);

    // Three requests, disable: drain until three final responses
    hs1(); hs1(); hs1();
    cfg(0, 0, 0);
    idle(); idle();
    chk("plan_stall_drain", 32'(req_stall_o), 1);
    fin(5); fin(5); fin(5);
    chk("plan_select_c1", 32'(select_o), 1);
    idle();
    chk("plan_select_c2", 32'(select_o), 0);
    idle();

    // Saturation at MAX_OUT
    cfg(1, 2, 5); idle(); idle();
    for (int i = 0; i < 15; i++) hs1();
    chk("plan_stall_full", 32'(req_stall_o), 1);
    step(0, 0, 0, 0, 1, 1, 1, 1, 5);
    chk("plan_stall_still_full", 32'(req_stall_o), 1);
    for (int i = 0; i < 11; i++) fin(5);
    chk("plan_stall_cnt4", 32'(req_stall_o), 0);
    cfg(1, 6, 1);
    idle();

    // Asynchronous reset in the middle of the drain
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) idle();
    chk("plan_no_pending_applied", 32'(select_o), 0);

    // Request during drain
    cfg(1, 2, 5); idle(); idle();
    hs1(); hs1();
    cfg(0, 0, 0);
    hs1();
    chk("plan_err_set", 32'(err_o), ERR_EN);
    idle();
    fin(5); fin(5); fin(5);
    idle(); idle(); idle();
    chk("plan_err_sticky", 32'(err_o), ERR_EN);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      bit cv, hs, rv, rr, rl;
      int rd;
      cv = ($urandom_range(0, 7) == 0);
      hs = (exp_stall() == 0) && ($urandom_range(0, 1) == 1);
      rv = ($urandom_range(0, 1) == 1);
      rr = ($urandom_range(0, 3) != 0);
      rl = ($urandom_range(0, 1) == 1);
      rd = ($urandom_range(0, 1) == 1) ? m_tgt : int'($urandom_range(0, 7));
      step(cv, $urandom_range(0, 3) != 0, int'($urandom_range(0, 7)),
           int'($urandom_range(0, 7)), hs, rv, rr, rl, rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
